// File: rtl/tb_end_ctrl_pkg.sv
// Shared definitions for the n100 end-of-test sequencer.
// This package holds the state encoding, the default tohost PC and a helper for sizing counters.
`ifndef N100_XLEN
`define N100_XLEN 32
`endif

package tb_end_ctrl_pkg;

    localparam int DEFAULT_XLEN = `N100_XLEN;

    localparam logic [31:0] TOHOST_PC_DEFAULT = 32'h0000_0080;

    typedef enum logic [1:0] {
        TB_END_ARM   = 2'd0,
        TB_END_RUN   = 2'd1,
        TB_END_DRAIN = 2'd2,
        TB_END_DONE  = 2'd3
    } tb_end_state_e;

    // This returns the smallest width that can hold 0..max_val, and never less than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tb_sat_cnt.sv
// Saturating up-counter with an enable and a synchronous clear.
// The counter holds its value once it reaches MAX.
module tb_sat_cnt #(
    parameter int             W   = 32,
    parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/tb_end_ctrl.sv
// This block sequences the end of a test: it counts tohost retirements, halts the core, drains, samples x3 and reports.
// A watchdog ends hung tests. Every output is a register.
module tb_end_ctrl
    import tb_end_ctrl_pkg::*;
#(
    parameter int               XLEN           = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  TOHOST_PC      = XLEN'(TOHOST_PC_DEFAULT),
    parameter int               HIT_THRESHOLD  = 8,
    parameter int               ARM_DELAY      = 60,
    parameter int               DRAIN_CYCLES   = 10,
    parameter int               TIMEOUT_CYCLES = 100000
) (
    input  logic            tb_clk,
    input  logic            tb_rst,
    input  logic            cmt_valid,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic [XLEN-1:0] x3_val,
    output logic            halt_req,
    output logic            test_done,
    output logic            test_pass,
    output logic            test_timeout,
    output logic [31:0]     cycle_count,
    output logic [31:0]     valid_ir_count,
    output logic [31:0]     tohost_cycle,
    output logic [XLEN-1:0] final_x3
);

    localparam int ARM_W = cnt_width(ARM_DELAY);
    localparam int DRN_W = cnt_width(DRAIN_CYCLES);
    localparam int HIT_W = cnt_width(HIT_THRESHOLD);

    tb_end_state_e    state;
    logic [ARM_W-1:0] arm_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [HIT_W-1:0] hit_cnt;

    logic is_hit;
    logic thr_hit;
    logic arm_last;
    logic drain_last;
    logic timeout_now;

    assign is_hit      = cmt_valid && (cmt_pc == TOHOST_PC);
    assign thr_hit     = is_hit && (hit_cnt == HIT_W'(HIT_THRESHOLD - 1));
    assign arm_last    = (arm_cnt == ARM_W'(ARM_DELAY - 1));
    assign drain_last  = (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));
    assign timeout_now = (cycle_count == 32'(TIMEOUT_CYCLES - 1));

    tb_sat_cnt #(.W(32)) u_cycle_cnt (
        .clk (tb_clk),
        .clr (tb_rst),
        .en  (state != TB_END_DONE),
        .q   (cycle_count)
    );

    // Retires keep counting through DRAIN because in-flight instructions still complete.
    tb_sat_cnt #(.W(32)) u_ir_cnt (
        .clk (tb_clk),
        .clr (tb_rst),
        .en  (cmt_valid && (state != TB_END_DONE)),
        .q   (valid_ir_count)
    );

    tb_sat_cnt #(.W(ARM_W)) u_arm_cnt (
        .clk (tb_clk),
        .clr (tb_rst),
        .en  (state == TB_END_ARM),
        .q   (arm_cnt)
    );

    tb_sat_cnt #(.W(DRN_W)) u_drain_cnt (
        .clk (tb_clk),
        .clr (tb_rst),
        .en  (state == TB_END_DRAIN),
        .q   (drain_cnt)
    );

    tb_sat_cnt #(.W(HIT_W), .MAX(HIT_W'(HIT_THRESHOLD))) u_hit_cnt (
        .clk (tb_clk),
        .clr (tb_rst),
        .en  ((state == TB_END_RUN) && is_hit),
        .q   (hit_cnt)
    );

    always_ff @(posedge tb_clk) begin
        if (tb_rst) begin
            state        <= (ARM_DELAY == 0) ? TB_END_RUN : TB_END_ARM;
            halt_req     <= 1'b0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_timeout <= 1'b0;
            tohost_cycle <= '0;
            final_x3     <= '0;
        end else begin
            case (state)
                TB_END_ARM: begin
                    if (timeout_now) begin
                        state        <= TB_END_DONE;
                        halt_req     <= 1'b1;
                        test_done    <= 1'b1;
                        test_pass    <= 1'b0;
                        test_timeout <= 1'b1;
                        final_x3     <= x3_val;
                    end else if (arm_last) begin
                        state <= TB_END_RUN;
                    end
                end
                TB_END_RUN: begin
                    // The threshold hit takes priority over a watchdog expiry in the same cycle.
                    if (thr_hit) begin
                        state        <= TB_END_DRAIN;
                        halt_req     <= 1'b1;
                        tohost_cycle <= cycle_count;
                    end else if (timeout_now) begin
                        state        <= TB_END_DONE;
                        halt_req     <= 1'b1;
                        test_done    <= 1'b1;
                        test_pass    <= 1'b0;
                        test_timeout <= 1'b1;
                        final_x3     <= x3_val;
                    end
                end
                TB_END_DRAIN: begin
                    if (drain_last) begin
                        state     <= TB_END_DONE;
                        test_done <= 1'b1;
                        test_pass <= (x3_val == XLEN'(1));
                        final_x3  <= x3_val;
                    end
                end
                default: begin
                    state <= TB_END_DONE;
                end
            endcase
        end
    end

endmodule

// File: doc/tb_end_ctrl.md
Name: tb_end_ctrl

Overview:
- Synthesizable end-of-test sequencer for the n100 core simulation environment. It watches the core's retire stream and counts retirements at the tohost PC.
- After a programmable number of tohost hits, it requests a core halt, lets in-flight instructions drain, samples x3, and publishes done/pass/fail plus cycle and instruction statistics.
- A watchdog ends hung tests. The bench monitor only waits on test_done and prints the outputs.

Parameters:
- XLEN, `N100_XLEN: data/PC width.
- TOHOST_PC, 32'h0000_0080: retire PC that counts as a tohost hit.
- HIT_THRESHOLD, 8: number of tohost hits that ends the test (≥1).
- ARM_DELAY, 60: cycles after reset during which hits are ignored (0 allowed).
- DRAIN_CYCLES, 10: cycles between halt request and x3 sampling (≥1).
- TIMEOUT_CYCLES, 100000: cycle_count value that forces a timeout.

Ports:
- tb_clk  in  1  clock.
- tb_rst  in  1  reset, synchronous, active-high.
- cmt_valid  in  1  one instruction retires this cycle.
- cmt_pc  in  XLEN  PC of the retiring instruction.
- x3_val  in  XLEN  current architectural x3.
- halt_req  out  1  request to the core to stop fetching.
- test_done  out  1  sticky, test finished.
- test_pass  out  1  sticky, final x3 == 1 and no timeout.
- test_timeout  out  1  sticky, watchdog fired.
- cycle_count  out  32  cycles since reset.
- valid_ir_count  out  32  retired instructions.
- tohost_cycle  out  32  cycle_count value at the threshold hit.
- final_x3  out  XLEN  x3 sampled at end of drain.

Behaviour:
- Reset: on a tb_clk edge with tb_rst=1:
  - all outputs, internal counters and hit_cnt go to 0;
  - state goes to ARM, or to RUN when ARM_DELAY=0.
  - Reset mid-operation, including in DRAIN or DONE, clears everything on that edge.
- States: ARM, RUN, DRAIN, DONE.
- cycle_count:
  - +1 every cycle not in DONE; saturates at 32'hFFFF_FFFF.
  - Reads 0 on the first cycle after reset.
- valid_ir_count: +1 per cmt_valid in ARM, RUN and DRAIN (in-flight retires count); saturating.
- ARM:
  - arm_cnt increments each cycle; tohost hits are ignored.
  - Goes to RUN on the edge where arm_cnt == ARM_DELAY-1.
- RUN:
  - A hit is cmt_valid && cmt_pc == TOHOST_PC; each hit increments hit_cnt.
  - On the hit that makes hit_cnt == HIT_THRESHOLD (cycle N):
    - tohost_cycle <= cycle_count of cycle N;
    - state goes to DRAIN; halt_req = 1 from cycle N+1.
- Timeout:
  - In ARM or RUN, when cycle_count == TIMEOUT_CYCLES-1, the next edge goes to DONE with test_timeout=1, test_pass=0, test_done=1, and final_x3 <= x3_val.
  - If the threshold hit and the timeout fall in the same cycle, the hit wins: go to DRAIN, no timeout.
  - DRAIN is never timed out.
- DRAIN:
  - halt_req = 1; hits are ignored; drain_cnt counts 0..DRAIN_CYCLES-1.
  - On the edge leaving the last drain cycle: final_x3 <= x3_val, test_pass <= (x3_val == 1), test_done <= 1, state goes to DONE.
  - Latency: test_done is high from cycle N+1+DRAIN_CYCLES.
- DONE:
  - All outputs are frozen and sticky; halt_req stays 1.
  - Stays in DONE until tb_rst; further cmt_valid has no effect.
- hit_cnt saturates at HIT_THRESHOLD.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package/defines:
  - state encoding (TB_END_ARM/RUN/DRAIN/DONE, 2-bit);
  - the tohost PC default;
  - XLEN taken from n100_defines.
- Sub-module tb_sat_cnt: parameterized-width saturating counter with enable and synchronous clear. Used for cycle_count, valid_ir_count, arm_cnt, drain_cnt and hit_cnt.

Test Plan:
1. ARM_DELAY=4, DRAIN=10: after ARM, drive 8 retires at 0x80 interleaved with 20 other retires, x3=1 → halt_req rises the cycle after the 8th hit; test_done=1 and test_pass=1 ten cycles later; valid_ir_count=28 plus any drain retires; tohost_cycle equals cycle_count at the 8th hit.
2. Same stimulus with x3_val=5 → test_done=1, test_pass=0, test_timeout=0, final_x3=5.
3. Three hits during ARM, then 8 hits in RUN → DRAIN entered only on the 8th RUN hit; tohost_cycle matches that cycle.
4. TIMEOUT_CYCLES=200, no hits → test_done and test_timeout=1 at cycle 200, test_pass=0, cycle_count frozen at 200.
5. tb_rst pulsed for one cycle in DRAIN → all outputs 0 next cycle, state ARM; a repeat of scenario 1 then passes normally.
6. 8th hit lands on cycle TIMEOUT_CYCLES-1 → DRAIN path taken, test_timeout=0, test_pass follows x3.
